// File: rtl/aes_word_loader.sv
// ---------------------------------------------------------------------------
// aes_word_loader
//
// Stream adapter that sits between the bus/DMA side and the AES core.
// It collects four 32-bit plaintext words into a 128-bit block, launches the
// core with a one-cycle start pulse, captures the ciphertext when the core
// signals completion, and streams the result back out as four 32-bit words.
//
// Parameters
//   WORD_ORDER  0: first stream word <-> bits [127:96] (MSB-first)
//               1: first stream word <-> bits [31:0]
//               The same mapping is used for the input and output streams.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   in_valid    plaintext word valid
//   in_ready    loader can accept a word (input buffer not full)
//   in_data     plaintext word
//   out_valid   ciphertext word valid
//   out_ready   downstream accepts the word
//   out_data    ciphertext word
//   out_last    marks the 4th word of a block
//   aes_start   one-cycle start pulse to the core
//   aes_plain   assembled plaintext block to the core
//   aes_busy    core busy
//   aes_done    core completion pulse
//   aes_cipher  core ciphertext, valid while aes_done=1
//   err         sticky protocol error (completion seen outside RUN)
// ---------------------------------------------------------------------------
module aes_word_loader #(
  parameter int WORD_ORDER = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         aes_start,
  output logic [127:0] aes_plain,
  input  logic         aes_busy,
  input  logic         aes_done,
  input  logic [127:0] aes_cipher,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t         state;
  logic [127:0]   in_buf;
  logic [127:0]   out_buf;
  logic [2:0]     in_cnt;
  logic [2:0]     out_cnt;
  logic [1:0]     out_slot;

  // Stream slot (0 = first word) to 32-bit lane position inside the block.
  function automatic logic [1:0] slot_pos(input logic [1:0] slot);
    if (WORD_ORDER != 0) begin
      return slot;
    end
    return 2'd3 - slot;
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] blk,
                                            input logic [1:0]   slot,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = blk;
    r[{slot_pos(slot), 5'd0} +: 32] = w;
    return r;
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] blk,
                                           input logic [1:0]   slot);
    return blk[{slot_pos(slot), 5'd0} +: 32];
  endfunction

  // Buffers, counters and launch/capture FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_cnt    <= 3'd0;
      out_cnt   <= 3'd0;
      in_buf    <= '0;
      out_buf   <= '0;
      aes_start <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        in_buf <= put_word(in_buf, in_cnt[1:0], in_data);
        in_cnt <= in_cnt + 3'd1;
      end

      if (out_valid && out_ready) begin
        out_cnt <= out_cnt - 3'd1;
      end

      // A completion pulse we did not ask for is a core/protocol fault.
      if (aes_done && (state != RUN)) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Launch only once the previous result has fully drained, so a
          // capture can never collide with an output transfer.
          if ((in_cnt == 3'd4) && (out_cnt == 3'd0) && !aes_busy) begin
            state     <= LAUNCH;
            aes_start <= 1'b1;
          end
        end
        LAUNCH: begin
          // The core samples aes_plain on this edge, so the input buffer
          // is free to refill from here on.
          state     <= RUN;
          aes_start <= 1'b0;
          in_cnt    <= 3'd0;
        end
        RUN: begin
          if (aes_done) begin
            state   <= IDLE;
            out_buf <= aes_cipher;
            out_cnt <= 3'd4;
          end
        end
        default: begin
          state     <= IDLE;
          aes_start <= 1'b0;
        end
      endcase
    end
  end

  // out_cnt counts down 4..1, so the word index is 4 - out_cnt (mod 4).
  assign out_slot  = 2'(3'd4 - out_cnt);

  assign in_ready  = (in_cnt != 3'd4);
  assign aes_plain = in_buf;
  assign out_valid = (out_cnt != 3'd0);
  assign out_last  = (out_cnt == 3'd1);
  assign out_data  = get_word(out_buf, out_slot);

endmodule

// File: tb/tb_aes_word_loader.sv
module tb_aes_word_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;

  // DUT with WORD_ORDER = 0
  logic         in_valid, in_ready, out_valid, out_ready, out_last;
  logic         aes_start, aes_busy, aes_done, err;
  logic [31:0]  in_data, out_data;
  logic [127:0] aes_plain, aes_cipher;

  // DUT with WORD_ORDER = 1 (directed check only)
  logic         in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
  logic         aes_start1, aes_busy1, aes_done1, err1;
  logic [31:0]  in_data1, out_data1;
  logic [127:0] aes_plain1, aes_cipher1;

  aes_word_loader #(.WORD_ORDER(0)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .aes_start(aes_start), .aes_plain(aes_plain),
    .aes_busy(aes_busy), .aes_done(aes_done), .aes_cipher(aes_cipher),
    .err(err)
  );

  aes_word_loader #(.WORD_ORDER(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_last(out_last1), .aes_start(aes_start1), .aes_plain(aes_plain1),
    .aes_busy(aes_busy1), .aes_done(aes_done1), .aes_cipher(aes_cipher1),
    .err(err1)
  );

  // ---------------- core stand-in ----------------
  logic         core_busy, core_done, spur_done, fixed_en;
  logic [127:0] core_cipher, core_blk;
  int           core_cnt;

  function automatic logic [127:0] core_fn(input logic [127:0] b);
    if (fixed_en) return 128'h0123456789abcdeffedcba9876543210;
    return {b[94:0], b[127:95]} ^ 128'h5a5ac3c30f0f9696a5a53c3cf0f06969;
  endfunction

  // Samples the block on the start edge, completion seen 16 edges later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_busy   <= 1'b0;
      core_done   <= 1'b0;
      core_cnt    <= 0;
      core_cipher <= '0;
      core_blk    <= '0;
    end else begin
      core_done <= 1'b0;
      if (!core_busy) begin
        if (aes_start) begin
          core_busy <= 1'b1;
          core_cnt  <= 0;
          core_blk  <= aes_plain;
        end
      end else if (core_cnt == 14) begin
        core_done   <= 1'b1;
        core_cipher <= core_fn(core_blk);
        core_cnt    <= 15;
      end else if (core_cnt == 15) begin
        core_busy <= 1'b0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  assign aes_busy   = core_busy;
  assign aes_done   = core_done | spur_done;
  assign aes_cipher = core_cipher;

  // ---------------- reference model ----------------
  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];

  function automatic void model_push(input logic [31:0] w);
    logic [127:0] blk, c;
    in_q.push_back(w);
    if (in_q.size() == 4) begin
      blk = {in_q[0], in_q[1], in_q[2], in_q[3]};
      c   = core_fn(blk);
      exp_q.push_back(c[127:96]);
      exp_q.push_back(c[95:64]);
      exp_q.push_back(c[63:32]);
      exp_q.push_back(c[31:0]);
      in_q.delete();
    end
  endfunction

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) break;
    end
    if (n > 500) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_push(w);
    end
  endtask

  task automatic drain_block(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdeadbeef;
      chk({tag, "_data"}, out_data, e);
      chk({tag, "_last"}, out_last, (j == 3));
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_empty"}, out_valid, 0);
  endtask

  logic [31:0] vec [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] ow   [4] = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, start_k, rise_k, n, found, rx, cyc;
    logic stable;
    logic [31:0] hold, e;

    rst = 1'b0;
    in_valid = 0; in_data = 0; out_ready = 0;
    in_valid1 = 0; in_data1 = 0; out_ready1 = 0;
    aes_busy1 = 0; aes_done1 = 0; aes_cipher1 = 0;
    spur_done = 0; fixed_en = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_aes_plain", aes_plain, 0);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed vector with latency check
    fixed_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(vec[i]);
    chk("d1_ready_drop", in_ready, 0);
    starts = 0; start_k = -1; rise_k = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (aes_start) begin
        starts++;
        start_k = k;
        chk("d1_plain", aes_plain, 128'h00112233445566778899aabbccddeeff);
      end
      if (k == 2) chk("d1_ready_rise", in_ready, 1);
      if (out_valid) begin
        rise_k = k;
        break;
      end
    end
    chk("d1_start_count", starts, 1);
    chk("d1_start_cycle", start_k, 1);
    chk("d1_valid_cycle", rise_k, 18);
    for (int j = 0; j < 4; j++) begin
      chk("d1_word", out_data, ow[j]);
      chk("d1_model", out_data, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdeadbeef);
      chk("d1_last", out_last, (j == 3));
      tick();
    end
    chk("d1_empty", out_valid, 0);
    out_ready = 1'b0;
    fixed_en = 1'b0;

    // WORD_ORDER = 1 instance
    for (int i = 0; i < 4; i++) begin
      in_valid1 = 1'b1;
      in_data1 = vec[i];
      tick();
    end
    in_valid1 = 1'b0;
    n = 0;
    while (!aes_start1 && n < 5) begin
      tick();
      n++;
    end
    chk("wo1_start", aes_start1, 1);
    chk("wo1_plain", aes_plain1, 128'hccddeeff8899aabb4455667700112233);
    tick();
    aes_cipher1 = 128'h0123456789abcdeffedcba9876543210;
    aes_done1 = 1'b1;
    tick();
    aes_done1 = 1'b0;
    chk("wo1_valid", out_valid1, 1);
    out_ready1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("wo1_word", out_data1, ow[3 - j]);
      chk("wo1_last", out_last1, (j == 3));
      tick();
    end
    out_ready1 = 1'b0;
    chk("wo1_empty", out_valid1, 0);
    chk("wo1_err", err1, 0);

    // Output back-pressure with a second block queued
    for (int i = 0; i < 4; i++) push_word($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("stall_valid", out_valid, 1);
    hold = out_data;
    for (int i = 0; i < 4; i++) push_word($urandom);
    chk("stall_in_ready", in_ready, 0);
    stable = 1'b1;
    starts = 0;
    for (int k = 0; k < 36; k++) begin
      tick();
      if (out_data !== hold || !out_valid) stable = 1'b0;
      if (aes_start) starts++;
    end
    chk("stall_stable", stable, 1);
    chk("stall_no_start", starts, 0);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdeadbeef;
      chk("stall_a_data", out_data, e);
      chk("stall_a_last", out_last, (j == 3));
      tick();
    end
    out_ready = 1'b0;
    found = 0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      if (aes_start) found = 1;
    end
    chk("stall_restart", found, 1);
    drain_block("stall_b");

    // Spurious completion while idle
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_no_valid", out_valid, 0);
    repeat (5) tick();
    chk("spur_err_sticky", err, 1);
    chk("spur_no_valid2", out_valid, 0);
    for (int i = 0; i < 4; i++) push_word($urandom);
    drain_block("spur_blk");
    chk("spur_err_after", err, 1);

    // Random traffic: 8 blocks, random gaps and back-pressure
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          push_word($urandom);
        end
      end
      begin
        rx = 0;
        cyc = 0;
        while (rx < 32 && cyc < 4000) begin
          tick();
          cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rand_extra", 1, 0);
            end else begin
              chk("rand_data", out_data, exp_q.pop_front());
              chk("rand_last", out_last, (rx % 4 == 3));
            end
            rx++;
          end
        end
        chk("rand_count", rx, 32);
      end
    join
    tick();
    out_ready = 1'b0;
    chk("rand_leftover", exp_q.size(), 0);

    // Asynchronous reset mid-RUN with a partial next block
    for (int i = 0; i < 4; i++) push_word($urandom);
    n = 0;
    while (!aes_start && n < 10) begin
      tick();
      n++;
    end
    chk("rstrun_start", aes_start, 1);
    repeat (3) tick();
    push_word($urandom);
    push_word($urandom);
    #3;
    rst = 1'b0;
    #2;
    chk("rstrun_in_ready", in_ready, 1);
    chk("rstrun_out_valid", out_valid, 0);
    chk("rstrun_out_last", out_last, 0);
    chk("rstrun_out_data", out_data, 0);
    chk("rstrun_plain", aes_plain, 0);
    chk("rstrun_start0", aes_start, 0);
    chk("rstrun_err", err, 0);
    in_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push_word($urandom);
    drain_block("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_word_loader.md
# aes_word_loader

Stream adapter on both sides of the AES core. It takes 32-bit plaintext words on a valid/ready input stream and packs four of them into a 128-bit block. It launches the core with a one-cycle start pulse, captures the ciphertext when the core signals completion, and returns it as four 32-bit words on a valid/ready output stream. It sits between the peripheral bus/DMA logic and the AES core.

## Interface
- WORD_ORDER, 0, 0: first stream word maps to bits [127:96] (MSB-first); 1: first word maps to bits [31:0]. Applies to both directions.

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- in_valid  in  1  input word valid
- in_ready  out  1  loader can accept a word
- in_data  in  32  plaintext word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  32  ciphertext word
- out_last  out  1  marks 4th word of a block
- aes_start  out  1  one-cycle start pulse to core
- aes_plain  out  128  assembled plaintext block to core
- aes_busy  in  1  core busy
- aes_done  in  1  core completion pulse (core status output)
- aes_cipher  in  128  core ciphertext, valid while aes_done=1
- err  out  1  sticky protocol error

## Operation
- The input buffer is a 128-bit register plus in_cnt (0..4). A word is accepted when in_valid && in_ready and written into slot in_cnt; in_cnt then increments. in_ready = (in_cnt != 4). aes_plain is driven directly from the buffer.
- Core FSM states: IDLE, LAUNCH, RUN.
  - IDLE → LAUNCH when in_cnt==4, the output buffer is empty, and aes_busy==0. aes_start is registered high on this transition.
  - LAUNCH lasts exactly one cycle with aes_start=1. On leaving it: in_cnt←0, aes_start←0, state←RUN.
  - RUN → IDLE on aes_done=1. On that edge aes_cipher is captured into the output buffer and out_cnt←4.
- Output buffer: out_cnt (0..4). out_valid = (out_cnt != 0). out_data = word (4−out_cnt) in WORD_ORDER. out_last = (out_cnt==1). A transfer (out_valid && out_ready) decrements out_cnt.
- Refill overlap: the input buffer may refill while in RUN or while the output drains. The next launch waits until out_cnt==0.
- Spurious completion: aes_done outside RUN is ignored for data, sets err=1, and err stays set until reset.
- Reset (rst=0, any time, including mid-RUN): in_cnt=0, out_cnt=0, FSM=IDLE. In-flight data is discarded.

## Timing
- Reset values: aes_start=0, out_valid=0, out_last=0, out_data=0, aes_plain=0, err=0. in_ready=1 because in_cnt=0.
- Let edge E be the edge that accepts the 4th word. With the core idle and the output empty:
  - aes_start is high during the cycle after E+1.
  - The core samples the block at E+2.
  - The core pulses aes_done 15 edges later; the pulse is seen at edge E+18.
  - out_valid rises after E+18. Loader latency is therefore 2 cycles launch plus 1 cycle capture.
- in_ready drops the cycle after E and rises again after edge E+2.
- Back-to-back input is sustained at 1 word/cycle. Output streams at 1 word/cycle while out_ready=1.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- aes_done arriving on the same edge as the last output transfer cannot occur, because launch requires out_cnt==0.

## Test plan
- Four words 00112233, 44556677, 8899aabb, ccddeeff back-to-back, out_ready=1, core stubbed to return 0x0123456789abcdeffedcba9876543210 → aes_plain=00112233445566778899aabbccddeeff; aes_start high for exactly 1 cycle at E+1; out words 01234567, 89abcdef, fedcba98, 76543210 with out_last on the 4th; out_valid rises 18 cycles after E.
- Real core with a golden model: 8 random blocks, random in_valid gaps and random out_ready → every block's ciphertext matches the model, in order, with no word loss or duplication.
- out_ready held 0 for 40 cycles after out_valid rises while a second block is fully written → out_data stable; in_ready=0 after 4 words; no second aes_start until the 4th output transfer completes; then start follows within 2 cycles.
- aes_done pulsed while IDLE → err=1 and stays 1; out_valid remains 0; a subsequent normal block still completes correctly.
- rst driven to 0 mid-RUN after 2 input words of the next block → all outputs return to reset values asynchronously; after release, a fresh 4-word block completes normally.
- WORD_ORDER=1 with the vector from the first scenario → aes_plain=ccddeeff8899aabb4455667700112233; output words come out in reversed slot order (76543210 first).
